// File: rtl/full_adder_4bits.sv
// Registered ripple-carry adder: {cout, sum} = inA + inB + cin, one-cycle latency.
// Ports: clock, reset (sync, active-low), inA/inB/cin/in_valid in; sum/cout/overflow/out_valid out.

// Single-bit full-adder cell; the ripple chain is built from one per bit.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);

endmodule

module full_adder_4bits #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             ovf_d;
    logic             ovf_q;
    logic             vld_d;
    logic             vld_q;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a_i (inA[i]),
            .b_i (inB[i]),
            .c_i (c[i]),
            .s_o (s[i]),
            .c_o (c[i+1])
        );
    end

    // Hold the previous result when no operands arrive; valid drops.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        vld_d  = in_valid;
        if (in_valid) begin
            sum_d  = s;
            cout_d = c[WIDTH];
            // Signed overflow: carry into MSB disagrees with carry out.
            ovf_d  = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    // Reset wins over a capture on the same edge, discarding that result.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder_4bits.sv
// Directed bench for full_adder_4bits: reset, corner vectors, streaming,
// hold behaviour and an exhaustive 4-bit sweep with a mid-sweep reset.
module tb_full_adder_4bits;

    logic       clock;
    logic       reset;
    logic [3:0] inA;
    logic [3:0] inB;
    logic       cin;
    logic       in_valid;
    logic [3:0] sum;
    logic       cout;
    logic       overflow;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    full_adder_4bits #(.WIDTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .inA       (inA),
        .inB       (inB),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operand set, advance one edge, sample 1 time unit later.
    task automatic step(input logic rst, input logic [3:0] a,
                        input logic [3:0] b, input logic ci,
                        input logic v);
        reset    = rst;
        inA      = a;
        inB      = b;
        cin      = ci;
        in_valid = v;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] s,
                              input logic co, input logic ov,
                              input logic v);
        chk({tag, ".sum"}, {4'h0, sum}, {4'h0, s});
        chk({tag, ".cout"}, {7'h0, cout}, {7'h0, co});
        chk({tag, ".ovf"}, {7'h0, overflow}, {7'h0, ov});
        chk({tag, ".vld"}, {7'h0, out_valid}, {7'h0, v});
    endtask

    initial begin
        logic [4:0] full;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       eov;

        reset    = 1'b0;
        inA      = 4'h0;
        inB      = 4'h0;
        cin      = 1'b0;
        in_valid = 1'b0;

        // Reset held with valid operands present.
        step(1'b0, 4'hF, 4'hF, 1'b1, 1'b1);
        expect_out("rst1", 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'hF, 4'hF, 1'b1, 1'b1);
        expect_out("rst2", 4'h0, 1'b0, 1'b0, 1'b0);

        step(1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
        expect_out("zero", 4'h0, 1'b0, 1'b0, 1'b1);

        step(1'b1, 4'hF, 4'h1, 1'b0, 1'b1);
        expect_out("f_1", 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'hF, 4'hF, 1'b1, 1'b1);
        expect_out("f_f_1", 4'hF, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'hF, 4'h0, 1'b1, 1'b1);
        expect_out("f_0_1", 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'h0, 4'h0, 1'b1, 1'b1);
        expect_out("cin_only", 4'h1, 1'b0, 1'b0, 1'b1);

        step(1'b1, 4'h7, 4'h1, 1'b0, 1'b1);
        expect_out("ovf_pos", 4'h8, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'h8, 4'h8, 1'b0, 1'b1);
        expect_out("ovf_neg", 4'h0, 1'b1, 1'b1, 1'b1);

        // Back-to-back stream, then hold.
        step(1'b1, 4'h5, 4'h3, 1'b1, 1'b1);
        expect_out("strm0", 4'h9, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'h2, 4'h2, 1'b0, 1'b1);
        expect_out("strm1", 4'h4, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'h9, 4'h6, 1'b1, 1'b1);
        expect_out("strm2", 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'h7, 4'h7, 1'b0, 1'b0);
        expect_out("hold0", 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h3, 4'h4, 1'b1, 1'b0);
        expect_out("hold1", 4'h0, 1'b1, 1'b0, 1'b0);

        // Exhaustive sweep; reset pulse at the midpoint.
        for (int i = 0; i < 512; i++) begin
            if (i == 256) begin
                step(1'b0, 4'hF, 4'hF, 1'b1, 1'b1);
                expect_out("mid_rst", 4'h0, 1'b0, 1'b0, 1'b0);
            end
            ea   = i[8:5];
            eb   = i[4:1];
            full = {1'b0, ea} + {1'b0, eb} + {4'h0, i[0]};
            eov  = (ea[3] == eb[3]) && (full[3] != ea[3]);
            step(1'b1, ea, eb, i[0], 1'b1);
            expect_out("sweep", full[3:0], full[4], eov, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
